alu_arbiter: RTL

Shares the single 16-bit `ALU` datapath between two requesters, such as the execute stage and an address/branch unit.
- Grants one requester per operation and registers its operands, then launches the ALU.
- Captures `ALU_Result` and `c` into a response register and holds them until the consumer accepts them.
- Sits between the requesting units and the combinational `ALU`, which it instantiates.

---
 rtl/alu_arbiter_pkg.sv | 28 ++
 rtl/ALU.sv | 30 +++
 rtl/alu_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: datapath widths, opcodes, FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_arbiter_pkg;

    localparam int ALU_W = 16;
    localparam int SEL_W = 2;

    // ALU operation selects
    localparam logic [SEL_W-1:0] SEL_ADD = 2'd0;  // {c,result} = a + b
    localparam logic [SEL_W-1:0] SEL_SUB = 2'd1;  // {c,result} = a - b, c is the borrow
    localparam logic [SEL_W-1:0] SEL_AND = 2'd2;  // result = a & b, c = 0
    localparam logic [SEL_W-1:0] SEL_OR  = 2'd3;  // result = a | b, c = 0

    // Arbiter FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // One granted operation as held in the operand registers
    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [SEL_W-1:0] sel;
        logic             id;
    } op_t;

endpackage

// File: rtl/ALU.sv
// Combinational 16-bit ALU: add, subtract (borrow in c), and, or.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
module ALU
    import alu_arbiter_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [SEL_W-1:0] sel,
    output logic [ALU_W-1:0] ALU_Result,
    output logic             c
);

    logic [ALU_W:0] wide;

    // Compute a 17-bit result; the top bit becomes the carry/borrow
    always_comb begin
        wide = '0;
        case (sel)
            SEL_ADD: wide = {1'b0, a} + {1'b0, b};
            SEL_SUB: wide = {1'b0, a} - {1'b0, b};
            SEL_AND: wide = {1'b0, a & b};
            default: wide = {1'b0, a | b};
        endcase
    end

    assign ALU_Result = wide[ALU_W-1:0];
    assign c          = wide[ALU_W];

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one ALU; ALU_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority (req0 wins).
// Latency: accept at edge N, resp_valid high after edge N+1; at most one op per 3 cycles.
// Backpressure: response held in RESP until resp_ready; no request is granted until the handshake completes.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [ALU_W-1:0] req0_a,
    input  logic [ALU_W-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [ALU_W-1:0] req1_a,
    input  logic [ALU_W-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [ALU_W-1:0] resp_result,
    output logic             resp_c,
    output logic             resp_id,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    logic [1:0]       state_q, state_d;
    op_t              op_q;
    logic [ALU_W-1:0] result_q;
    logic             c_q;
    logic             id_q;
    logic [CNT_W-1:0] cnt_q;

    logic             any_vld;
    logic             grant_id;
    logic             take;
    op_t              grant_op;
    logic [ALU_W-1:0] alu_result;
    logic             alu_c;

    assign any_vld = req0_valid | req1_valid;
    assign take    = (state_q == ST_IDLE) && any_vld;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_q;

    // Under contention hand the ALU to whoever did not win last time
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) grant_id = ~last_q;
        else                          grant_id = req1_valid;
    end

    // Remember the winner of every grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       last_q <= 1'b1;
        else if (take) last_q <= grant_id;
    end
`else
    // Fixed priority: requester 0 wins whenever it is valid
    always_comb begin
        grant_id = ~req0_valid;
    end
`endif

    // Readies depend only on state, valids and last grant; forced low during reset
    always_comb begin
        req0_ready = ~rst & take & ~grant_id;
        req1_ready = ~rst & take &  grant_id;
    end

    // Mux the winning requester's operands toward the operand register
    always_comb begin
        grant_op = grant_id ? op_t'{req1_a, req1_b, req1_sel, 1'b1}
                            : op_t'{req0_a, req0_b, req0_sel, 1'b0};
    end

    // IDLE -> EXEC on grant, EXEC -> RESP unconditionally, RESP -> IDLE on handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_vld)    state_d = ST_EXEC;
            ST_EXEC:                 state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // ALU only ever sees registered operands
    ALU u_alu (
        .a          (op_q.a),
        .b          (op_q.b),
        .sel        (op_q.sel),
        .ALU_Result (alu_result),
        .c          (alu_c)
    );

    // State, operand capture, response capture and completion counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            result_q <= '0;
            c_q      <= 1'b0;
            id_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (take) op_q <= grant_op;
            if (state_q == ST_EXEC) begin
                result_q <= alu_result;
                c_q      <= alu_c;
                id_q     <= op_q.id;
            end
            if ((state_q == ST_RESP) && resp_ready) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign resp_valid  = (state_q == ST_RESP);
    assign resp_result = result_q;
    assign resp_c      = c_q;
    assign resp_id     = id_q;
    assign busy        = (state_q != ST_IDLE);
    assign op_count    = cnt_q;

endmodule
